tlb_walker: RTL and testbench
=============================

# tlb_walker

Hardware page-table walker that refills the fully-associative TLB on a translation miss. The walker accepts a miss from the pipeline and reads a two-level page table over a 27-bit physical memory port. On success it drives the TLB write port (`we`/`read_addr`/`write_data`/`pid`) and the pipeline replays the access. On a not-present PTE it reports a fault code in the same 0x82/0x83 encoding the TLB uses.

## Interface
- `PTE_V_BIT`, 11: PTE present bit, at this position in both levels.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `clk_en` in 1: global stall. When low, all state, handshakes and outputs hold.
- `kmode` in 1: mode of the faulting access. Selects the fault code.
- `ptbr` in 27: level-1 table base. Bits [11:0] are ignored and treated as 0.
- `miss_valid` in 1: miss request.
- `miss_vaddr` in 32: faulting virtual address.
- `miss_pid` in 32: PID of the faulting access.
- `miss_ready` out 1: high only in IDLE.
- `abort` in 1: pipeline flush. Cancels any walk in progress.
- `mem_req` out 1: memory read request.
- `mem_addr` out 27: word address.
- `mem_ready` in 1: request accepted when `mem_req && mem_ready`.
- `mem_rvalid` in 1: read data valid, at least 1 cycle after acceptance.
- `mem_rdata` in 32: read data.
- `tlb_we` out 1: TLB write strobe.
- `tlb_read_addr` out 32: TLB key address, equal to `miss_vaddr` with [11:0] zeroed.
- `tlb_pid` out 32: PID for the TLB write.
- `tlb_write_data` out 32: `{5'b0, pte[26:0]}`.
- `walk_done` out 1: 1-cycle pulse; refill complete.
- `walk_fault` out 1: 1-cycle pulse; not-present PTE.
- `fault_code` out 8: 0x83 if `kmode`, else 0x82. Valid only with `walk_fault`; 0 otherwise.
- `busy` out 1: high in any state except IDLE.

## Operation
- VPN = `vaddr[31:12]`.
- L1 address = `{ptbr[26:12], vpn[19:10], 2'b00}`.
- L2 address = `{l1pte[26:12], vpn[9:0], 2'b00}`.
- PTE format: PPN in [26:12], flags in [11:0]; G/U/X/W/R in [4:0]; present bit at [PTE_V_BIT].
- Capture on acceptance: `vaddr`, `pid` and `kmode` are latched when `miss_valid && miss_ready`. `ptbr` is sampled at the same edge.
- States:
  - IDLE: on accept, go to L1_REQ.
  - L1_REQ: `mem_req`=1 with the L1 address. On `mem_ready`, go to L1_WAIT.
  - L1_WAIT: on `mem_rvalid`, if the present bit is clear go to FAULT, else latch `l1pte` and go to L2_REQ.
  - L2_REQ: `mem_req`=1 with the L2 address. On `mem_ready`, go to L2_WAIT.
  - L2_WAIT: on `mem_rvalid`, if the present bit is clear go to FAULT, else latch the PTE and go to FILL.
  - FILL: `tlb_we`=1 and `walk_done`=1 for one cycle, then go to IDLE.
  - FAULT: `walk_fault`=1 and `fault_code` driven for one cycle, then go to IDLE. The TLB is not written.
  - DRAIN: discard `mem_rvalid` data, then go to IDLE.
- Abort:
  - In L1_REQ/L2_REQ with `mem_ready` low: go to IDLE. `mem_req` drops next cycle.
  - In L1_REQ/L2_REQ with `mem_ready` high in the same cycle: the request is accepted; go to DRAIN.
  - In L1_WAIT/L2_WAIT: go to DRAIN, or to IDLE if `mem_rvalid` is high in the same cycle. The data is ignored.
  - In FILL/FAULT/IDLE: no effect. The write and pulse still occur.
  - An aborted walk never asserts `tlb_we`, `walk_done` or `walk_fault`.
- `tlb_read_addr`, `tlb_pid` and `tlb_write_data` are held stable from FILL until the next accept.
- Flags are copied unchanged. Permission checks remain in the TLB on the replayed access.

## Timing
- Reset values:
  - State is IDLE; `miss_ready`=1.
  - All other outputs are 0: `mem_req`, `mem_addr`, `tlb_we`, `tlb_read_addr`, `tlb_pid`, `tlb_write_data`, `walk_done`, `walk_fault`, `fault_code`, `busy`.
  - Reset mid-walk returns to IDLE immediately. An outstanding memory response is the memory side's responsibility to suppress on its own reset.
- All outputs are registered or decoded from the state register only. There are no combinational paths from inputs to outputs.
- `mem_req`/`mem_addr` stay asserted and stable until the accept cycle.
- Minimum latency with `mem_ready`=1 and `rvalid` 1 cycle after accept, accept at cycle N:
  - L1 request accepted at N+1.
  - L1 data at N+2.
  - L2 request accepted at N+3.
  - L2 data at N+4.
  - FILL at N+5; the TLB entry is visible from N+6.
- An L1 fault pulses at N+3.
- `miss_ready` is low from N+1 until the cycle after FILL/FAULT/DRAIN completion. A new miss can be accepted at the earliest in the cycle after FILL.
- With `clk_en` low, no handshake is sampled, including `mem_ready`/`mem_rvalid`. The memory side must hold its response.

## Test plan
- Hit path:
  - Setup: `ptbr`=0x10000, `vaddr`=0x00403ABC, `pid`=5, L1[1] (mem_addr 0x10004)=0x00020800, L2[3] (mem_addr 0x2000C)=0x0012381F.
  - Required: mem_addr 0x10004 then 0x2000C; `tlb_we` with `tlb_read_addr`=0x00403000, `tlb_pid`=5, `tlb_write_data`=0x0012381F; `walk_done` at N+5.
- L1 not present: L1 PTE=0x00020000 with `kmode`=0 -> `walk_fault` with `fault_code`=0x82, one memory read, no `tlb_we`.
- L2 not present: L2 PTE=0x0012301F with `kmode`=1 -> `fault_code`=0x83 after two reads.
- Memory backpressure: `mem_ready` low for 3 cycles, `rvalid` delayed 4 cycles -> `mem_req`/`mem_addr` held stable; result identical to the hit path.
- Abort in L2_WAIT: `rvalid` arrives 2 cycles later -> DRAIN consumes it; no `tlb_we` or pulses; `miss_ready` returns to 1; a following miss walks correctly.
- Stall and reset: `clk_en` low for 5 cycles mid-L1_REQ -> no progress, outputs frozen. Asserting `rst_n`=0 in L2_REQ -> all outputs 0 and `miss_ready`=1 asynchronously.

Source files
------------

// File: rtl/tlb_walker.sv
// Two-level hardware page-table walker.
// Refills the TLB on a translation miss or reports a not-present fault.
module tlb_walker #(
  parameter int PTE_V_BIT = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        kmode,
  input  logic [26:0] ptbr,
  input  logic        miss_valid,
  input  logic [31:0] miss_vaddr,
  input  logic [31:0] miss_pid,
  output logic        miss_ready,
  input  logic        abort,
  output logic        mem_req,
  output logic [26:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        tlb_we,
  output logic [31:0] tlb_read_addr,
  output logic [31:0] tlb_pid,
  output logic [31:0] tlb_write_data,
  output logic        walk_done,
  output logic        walk_fault,
  output logic [7:0]  fault_code,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, L1_REQ, L1_WAIT, L2_REQ,
    L2_WAIT, FILL, FAULT, DRAIN
  } state_e;

  state_e      state_q, state_d;
  logic [19:0] vpn_q, vpn_d;
  logic [31:0] pid_q, pid_d;
  logic        kmode_q, kmode_d;
  logic [14:0] base_q, base_d;
  logic [14:0] l1ppn_q, l1ppn_d;
  logic [31:0] raddr_q, raddr_d;
  logic [31:0] tpid_q, tpid_d;
  logic [31:0] wdata_q, wdata_d;
  logic        present;
  logic        unused_bits;

  assign present = mem_rdata[PTE_V_BIT];
  assign unused_bits = ^{ptbr[11:0], miss_vaddr[11:0], mem_rdata[31:27]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else if (clk_en) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (miss_valid) state_d = L1_REQ;
      L1_REQ:  if (abort) state_d = mem_ready ? DRAIN : IDLE;
               else if (mem_ready) state_d = L1_WAIT;
      L1_WAIT: if (abort) state_d = mem_rvalid ? IDLE : DRAIN;
               else if (mem_rvalid) state_d = present ? L2_REQ : FAULT;
      L2_REQ:  if (abort) state_d = mem_ready ? DRAIN : IDLE;
               else if (mem_ready) state_d = L2_WAIT;
      L2_WAIT: if (abort) state_d = mem_rvalid ? IDLE : DRAIN;
               else if (mem_rvalid) state_d = present ? FILL : FAULT;
      FILL:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      DRAIN:   if (mem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    miss_ready = (state_q == IDLE);
    busy       = (state_q != IDLE);
    mem_req    = (state_q == L1_REQ) || (state_q == L2_REQ);
    mem_addr   = '0;
    if (state_q == L1_REQ) mem_addr = {base_q, vpn_q[19:10], 2'b00};
    if (state_q == L2_REQ) mem_addr = {l1ppn_q, vpn_q[9:0], 2'b00};
    tlb_we     = (state_q == FILL);
    walk_done  = (state_q == FILL);
    walk_fault = (state_q == FAULT);
    fault_code = 8'h00;
    if (state_q == FAULT) fault_code = kmode_q ? 8'h83 : 8'h82;
  end

  assign tlb_read_addr  = raddr_q;
  assign tlb_pid        = tpid_q;
  assign tlb_write_data = wdata_q;

  always_comb begin
    vpn_d   = vpn_q;
    pid_d   = pid_q;
    kmode_d = kmode_q;
    base_d  = base_q;
    l1ppn_d = l1ppn_q;
    raddr_d = raddr_q;
    tpid_d  = tpid_q;
    wdata_d = wdata_q;
    if (state_q == IDLE && miss_valid) begin
      vpn_d   = miss_vaddr[31:12];
      pid_d   = miss_pid;
      kmode_d = kmode;
      base_d  = ptbr[26:12];
    end
    if (state_q == L1_WAIT && mem_rvalid && !abort) begin
      l1ppn_d = mem_rdata[26:12];
    end
    // TLB write payload is captured once so it stays stable after FILL
    if (state_q == L2_WAIT && mem_rvalid && !abort && present) begin
      raddr_d = {vpn_q, 12'h000};
      tpid_d  = pid_q;
      wdata_d = {5'b0, mem_rdata[26:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpn_q   <= '0;
      pid_q   <= '0;
      kmode_q <= 1'b0;
      base_q  <= '0;
      l1ppn_q <= '0;
      raddr_q <= '0;
      tpid_q  <= '0;
      wdata_q <= '0;
    end else if (clk_en) begin
      vpn_q   <= vpn_d;
      pid_q   <= pid_d;
      kmode_q <= kmode_d;
      base_q  <= base_d;
      l1ppn_q <= l1ppn_d;
      raddr_q <= raddr_d;
      tpid_q  <= tpid_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_tlb_walker.sv
// Bench for tlb_walker: memory model, scoreboard of
// expected reads and walk results, directed steps.
module tb_tlb_walker;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        clk_en = 1;
  logic        kmode = 0;
  logic [26:0] ptbr = 27'h10000;
  logic        miss_valid = 0;
  logic [31:0] miss_vaddr = 0;
  logic [31:0] miss_pid = 0;
  logic        miss_ready;
  logic        abort = 0;
  logic        mem_req;
  logic [26:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        tlb_we;
  logic [31:0] tlb_read_addr;
  logic [31:0] tlb_pid;
  logic [31:0] tlb_write_data;
  logic        walk_done;
  logic        walk_fault;
  logic [7:0]  fault_code;
  logic        busy;

  tlb_walker #(.PTE_V_BIT(11)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .kmode(kmode),
    .ptbr(ptbr), .miss_valid(miss_valid), .miss_vaddr(miss_vaddr),
    .miss_pid(miss_pid), .miss_ready(miss_ready), .abort(abort),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .tlb_we(tlb_we),
    .tlb_read_addr(tlb_read_addr), .tlb_pid(tlb_pid),
    .tlb_write_data(tlb_write_data), .walk_done(walk_done),
    .walk_fault(walk_fault), .fault_code(fault_code), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int done_cyc = 0;
  int flt_cyc = 0;
  int n_rd = 0;
  int n_we = 0;
  int n_done = 0;
  int n_flt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // memory model: ready after rdy_lat cycles of request, rvalid rv_lat after accept
  int          rdy_lat = 0;
  int          rv_lat = 1;
  int          rdy_cnt = 0;
  int          rv_cnt = 0;
  logic        pend = 0;
  logic [31:0] pend_data = 0;
  logic [31:0] mem [int];

  function automatic logic [31:0] memv(input logic [26:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return 32'h0;
  endfunction

  assign mem_ready  = (rdy_cnt >= rdy_lat);
  assign mem_rvalid = pend && (rv_cnt >= rv_lat);
  assign mem_rdata  = pend ? pend_data : 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_cnt <= 0;
      rv_cnt <= 0;
      pend <= 0;
      pend_data <= 0;
    end else if (clk_en) begin
      if (mem_req && mem_ready) begin
        rdy_cnt <= 0;
        pend <= 1;
        rv_cnt <= 1;
        pend_data <= memv(mem_addr);
      end else if (mem_req) begin
        rdy_cnt <= rdy_cnt + 1;
      end else begin
        rdy_cnt <= 0;
      end
      if (pend && mem_rvalid) pend <= 0;
      else if (pend) rv_cnt <= rv_cnt + 1;
    end
  end

  typedef struct {
    bit          fault;
    logic [31:0] ra;
    logic [31:0] pid;
    logic [31:0] wd;
    logic [7:0]  code;
  } ev_t;

  ev_t         exp_q[$];
  logic [26:0] exp_a[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic        hold_v = 0;
  logic [26:0] hold_a = 0;

  always @(negedge clk) begin
    if (rst_n && clk_en) begin
      if (miss_valid && miss_ready) acc_cyc = cyc + 1;
      if (hold_v && mem_req) chk("addr_hold", 32'(mem_addr), 32'(hold_a));
      hold_v = mem_req && !mem_ready;
      hold_a = mem_addr;
      if (mem_req && mem_ready) begin
        n_rd++;
        if (exp_a.size() == 0) chk("unexp_rd", 32'(mem_addr), 32'hFFFFFFFF);
        else chk("mem_addr", 32'(mem_addr), 32'(exp_a.pop_front()));
      end
      if (tlb_we) n_we++;
      if (!walk_fault) chk("fcode_zero", 32'(fault_code), 32'h0);
      if (walk_done || walk_fault) begin
        if (exp_q.size() == 0) begin
          chk("unexp_ev", {30'b0, walk_done, walk_fault}, 32'h0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("ev_kind", 32'(walk_fault), 32'(e.fault));
          if (e.fault) begin
            chk("fcode", 32'(fault_code), 32'(e.code));
            chk("flt_we", 32'(tlb_we), 32'h0);
            flt_cyc = cyc + 1;
            n_flt++;
          end else begin
            chk("fill_we", 32'(tlb_we), 32'h1);
            chk("fill_ra", tlb_read_addr, e.ra);
            chk("fill_pid", tlb_pid, e.pid);
            chk("fill_wd", tlb_write_data, e.wd);
            done_cyc = cyc + 1;
            n_done++;
          end
        end
      end
    end
  end

  task automatic push_hit(input logic [31:0] p);
    exp_a.push_back(27'h10004);
    exp_a.push_back(27'h2000C);
    exp_q.push_back('{0, 32'h00403000, p, 32'h0012381F, 8'h00});
  endtask

  task automatic do_miss(input logic [31:0] va, input logic [31:0] p,
                         input logic km);
    int k;
    @(posedge clk);
    #1;
    miss_vaddr = va;
    miss_pid = p;
    kmode = km;
    miss_valid = 1;
    k = 0;
    @(negedge clk);
    while (!miss_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("miss_rdy", 32'(miss_ready), 32'h1);
    @(posedge clk);
    #1 miss_valid = 0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_idle"}, 32'(busy), 32'h0);
  endtask

  task automatic reset_outs(input string tag);
    chk({tag, "_mrdy"}, 32'(miss_ready), 32'h1);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_req"}, 32'(mem_req), 32'h0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'h0);
    chk({tag, "_we"}, 32'(tlb_we), 32'h0);
    chk({tag, "_ra"}, tlb_read_addr, 32'h0);
    chk({tag, "_pid"}, tlb_pid, 32'h0);
    chk({tag, "_wd"}, tlb_write_data, 32'h0);
    chk({tag, "_done"}, 32'(walk_done), 32'h0);
    chk({tag, "_flt"}, 32'(walk_fault), 32'h0);
    chk({tag, "_fc"}, 32'(fault_code), 32'h0);
  endtask

  int r0, w0, d0, f0, k;

  initial begin
    mem[32'h10004] = 32'h00020800;
    mem[32'h2000C] = 32'h0012381F;
    mem[32'h10008] = 32'h00020000;
    mem[32'h20014] = 32'h0012301F;
    #2;
    reset_outs("rst");
    #10 rst_n = 1;

    // hit path at minimum latency
    push_hit(5);
    do_miss(32'h00403ABC, 5, 0);
    wait_idle("hit");
    chk("hit_lat", done_cyc - acc_cyc, 5);
    chk("hit_rd", n_rd, 2);
    chk("hold_ra", tlb_read_addr, 32'h00403000);
    chk("hold_wd", tlb_write_data, 32'h0012381F);

    // L1 not present, user mode
    r0 = n_rd; w0 = n_we;
    exp_a.push_back(27'h10008);
    exp_q.push_back('{1, 0, 0, 0, 8'h82});
    do_miss(32'h00800123, 7, 0);
    wait_idle("l1f");
    chk("l1f_lat", flt_cyc - acc_cyc, 3);
    chk("l1f_rd", n_rd - r0, 1);
    chk("l1f_we", n_we - w0, 0);

    // L2 not present, kernel mode
    r0 = n_rd; w0 = n_we;
    exp_a.push_back(27'h10004);
    exp_a.push_back(27'h20014);
    exp_q.push_back('{1, 0, 0, 0, 8'h83});
    do_miss(32'h00405000, 9, 1);
    wait_idle("l2f");
    chk("l2f_rd", n_rd - r0, 2);
    chk("l2f_we", n_we - w0, 0);
    chk("l2f_keep_pid", tlb_pid, 32'd5);

    // backpressure: ready low 3 cycles, rvalid 4 cycles after accept
    rdy_lat = 3; rv_lat = 4;
    w0 = n_we;
    push_hit(5);
    do_miss(32'h00403ABC, 5, 0);
    wait_idle("bp");
    chk("bp_lat", done_cyc - acc_cyc, 17);
    chk("bp_we", n_we - w0, 1);

    // abort in L2_WAIT, data arrives later and is drained
    rdy_lat = 0; rv_lat = 3;
    r0 = n_rd; w0 = n_we; d0 = n_done; f0 = n_flt;
    exp_a.push_back(27'h10004);
    exp_a.push_back(27'h2000C);
    do_miss(32'h00403ABC, 5, 0);
    k = 0;
    @(negedge clk);
    while (!(mem_req && mem_ready && mem_addr == 27'h2000C) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("ab_l2acc", 32'(mem_addr), 32'h2000C);
    @(posedge clk); #1 abort = 1;
    @(posedge clk); #1 abort = 0;
    wait_idle("ab");
    chk("ab_mrdy", 32'(miss_ready), 32'h1);
    chk("ab_rd", n_rd - r0, 2);
    chk("ab_we", n_we - w0, 0);
    chk("ab_done", n_done - d0, 0);
    chk("ab_flt", n_flt - f0, 0);
    chk("ab_drained", 32'(pend), 32'h0);
    rv_lat = 1;
    push_hit(6);
    do_miss(32'h00403ABC, 6, 0);
    wait_idle("ab2");
    chk("ab2_lat", done_cyc - acc_cyc, 5);

    // abort in L1_REQ while memory is not ready
    rdy_lat = 2;
    r0 = n_rd;
    do_miss(32'h00403ABC, 5, 0);
    abort = 1;
    @(posedge clk); #1 abort = 0;
    @(negedge clk);
    chk("abq_req", 32'(mem_req), 32'h0);
    chk("abq_mrdy", 32'(miss_ready), 32'h1);
    chk("abq_rd", n_rd - r0, 0);

    // stall for 5 edges while in L1_REQ
    rdy_lat = 0;
    d0 = n_done;
    push_hit(7);
    do_miss(32'h00403ABC, 7, 0);
    clk_en = 0;
    repeat (5) begin
      @(posedge clk); #2;
      chk("stl_req", 32'(mem_req), 32'h1);
      chk("stl_addr", 32'(mem_addr), 32'h10004);
      chk("stl_busy", 32'(busy), 32'h1);
    end
    clk_en = 1;
    wait_idle("stl");
    chk("stl_lat", done_cyc - acc_cyc, 10);
    chk("stl_done", n_done - d0, 1);

    // asynchronous reset while in L2_REQ
    rdy_lat = 2;
    exp_a.push_back(27'h10004);
    do_miss(32'h00403ABC, 5, 0);
    k = 0;
    @(negedge clk);
    while (!(mem_req && mem_addr == 27'h2000C) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("rs_l2req", 32'(mem_addr), 32'h2000C);
    #2 rst_n = 0;
    #1 reset_outs("arst");
    @(posedge clk); #1 rst_n = 1;
    chk("sb_addr_empty", exp_a.size(), 0);
    chk("sb_ev_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
